// File: rtl/led_blink_array.sv
// led_blink_array: per-channel OFF/ON/BLINK/PULSE LED drivers sharing one prescaler tick, configured via a valid/ready write port
module led_blink_array #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 25000,
  parameter int CH_W     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] pulse_done,
  output logic                cfg_err
);
  typedef enum logic [1:0] {OFF, ON, BLINK, PULSE} mode_e;
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] presc_q, presc_d;
  logic rdy_q, rdy_d, err_q, err_d;
  logic [CHANNELS-1:0] led_q, led_d, done_q, done_d, wr, wrap;
  mode_e mode_q [CHANNELS];
  mode_e mode_d [CHANNELS];
  logic [CNT_W-1:0] per_q [CHANNELS];
  logic [CNT_W-1:0] per_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [CNT_W-1:0] cnt_d [CHANNELS];
  logic tick, accept, chan_ok;
  assign tick    = presc_q == PW'(PRESCALE - 1);
  assign accept  = cfg_valid && rdy_q;
  assign chan_ok = {1'b0, cfg_chan} < (CH_W + 1)'(CHANNELS);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr[i]   = accept && ({1'b0, cfg_chan} == (CH_W + 1)'(i));
    assign wrap[i] = cnt_q[i] == per_q[i] - CNT_W'(1);
  end
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    rdy_d   = !accept;
    err_d   = accept && !chan_ok;
    led_d   = led_q;
    done_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i] = mode_q[i];
      per_d[i]  = per_q[i];
      cnt_d[i]  = cnt_q[i];
      if (wr[i]) begin
        mode_d[i] = mode_e'(cfg_mode);
        per_d[i]  = (cfg_period == '0) ? CNT_W'(1) : cfg_period;
        cnt_d[i]  = '0;
        led_d[i]  = mode_e'(cfg_mode) != OFF;
      end else if (tick && (mode_q[i] == BLINK || mode_q[i] == PULSE)) begin
        cnt_d[i]  = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
        led_d[i]  = wrap[i] ? (mode_q[i] == BLINK && !led_q[i]) : led_q[i];
        done_d[i] = wrap[i] && mode_q[i] == PULSE;
        mode_d[i] = (wrap[i] && mode_q[i] == PULSE) ? OFF : mode_q[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= '0;
      done_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i] <= OFF;
        per_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      presc_q <= presc_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      led_q   <= led_d;
      done_q  <= done_d;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i] <= mode_d[i];
        per_q[i]  <= per_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end
  assign cfg_ready  = rdy_q;
  assign cfg_err    = err_q;
  assign led        = led_q;
  assign pulse_done = done_q;
endmodule

// File: tb/tb_led_blink_array.sv
// tb_led_blink_array: scoreboard bench comparing the DUT against a tick-counting reference model
module tb_led_blink_array;
  localparam int CH = 4, CW = 8, P = 4, CHW = 3;
  logic clk = 1'b0, reset = 1'b1, cfg_valid = 1'b0, cfg_ready, cfg_err;
  logic [CHW-1:0] cfg_chan = '0;
  logic [1:0] cfg_mode = '0;
  logic [CW-1:0] cfg_period = '0;
  logic [CH-1:0] led, pulse_done;
  typedef struct {logic [CH-1:0] led; logic [CH-1:0] done; logic err; logic rdy;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int m_mode [CH];
  int m_per [CH];
  int m_w [CH];
  int cyc = 0;
  bit m_rdy = 1'b0;
  led_blink_array #(.CHANNELS(CH), .CNT_W(CW), .PRESCALE(P), .CH_W(CHW)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .led(led), .pulse_done(pulse_done), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  function automatic int ticks(int c);
    return (c + 1) / P;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic step(bit r, bit v, int ch, int md, int per);
    exp_t e;
    bit acc, t;
    int n;
    @(negedge clk);
    reset = r; cfg_valid = v; cfg_chan = ch[CHW-1:0]; cfg_mode = md[1:0]; cfg_period = per[CW-1:0];
    e.led = '0; e.done = '0; e.err = 1'b0; e.rdy = 1'b0;
    if (r) begin
      for (int i = 0; i < CH; i++) m_mode[i] = 0;
      m_rdy = 1'b0;
      cyc = 0;
    end else begin
      acc = v && m_rdy;
      t = (cyc % P) == P - 1;
      for (int i = 0; i < CH; i++) begin
        if (acc && ch == i) begin
          m_mode[i] = md; m_per[i] = (per == 0) ? 1 : per; m_w[i] = cyc;
        end else if (m_mode[i] == 3 && t && ticks(cyc) - ticks(m_w[i]) == m_per[i]) begin
          e.done[i] = 1'b1; m_mode[i] = 0;
        end
        n = (m_mode[i] == 0) ? 0 : ticks(cyc) - ticks(m_w[i]);
        e.led[i] = m_mode[i] == 0 ? 1'b0 : m_mode[i] == 2 ? ((n / m_per[i]) % 2 == 0) : 1'b1;
      end
      e.err = acc && ch >= CH;
      m_rdy = !acc;
      e.rdy = m_rdy;
      cyc++;
    end
    q.push_back(e);
  endtask
  task automatic idle(int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("led", 32'(led), 32'(e.led));
        chk("pulse_done", 32'(pulse_done), 32'(e.done));
        chk("cfg_err", 32'(cfg_err), 32'(e.err));
        chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
      end
    end
  end
  initial begin
    for (int i = 0; i < CH; i++) begin m_mode[i] = 0; m_per[i] = 1; m_w[i] = 0; end
    repeat (3) step(1, 0, 0, 0, 0);
    idle(40);
    step(0, 1, 0, 2, 2);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 3, 3);
    idle(40);
    step(0, 1, 5, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 3, i % 2, 0);
    step(0, 1, 2, 2, 0);
    idle(20);
    for (int i = 0; i < 20 && !((cyc % P) == P - 1 && m_rdy); i++) step(0, 0, 0, 0, 0);
    step(0, 1, 2, 2, 1);
    idle(20);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5),
           $urandom_range(0, 3), $urandom_range(0, 4));
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 2, 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 3, 5);
    idle(3);
    step(1, 1, 3, 1, 2);
    step(1, 0, 0, 0, 0);
    idle(30);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
